// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings shared by the ALU and its bench
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;
endpackage

// File: rtl/alu_nbit_addsub.sv
// alu_nbit_addsub: n-bit adder/subtractor with carry/borrow in and out
module alu_nbit_addsub #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cb_in,
    input  logic         sub,
    output logic [n-1:0] sum,
    output logic         cb_out
);
    // In n+1 bits a negative difference sets the top bit, which is exactly the borrow
    assign {cb_out, sum} = sub ? {1'b0, a} - {1'b0, b} - {{n{1'b0}}, cb_in}
                               : {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cb_in};
endmodule

// File: rtl/alu_nbit.sv
// alu_nbit: registered n-bit ALU with cascadable carry/borrow
module alu_nbit
    import alu_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [2:0]   Mode,
    input  logic         CB_in,
    output logic [n-1:0] Result,
    output logic         CB_out
);
    logic         arith;
    logic         use_sub;
    logic [n-1:0] as_b;
    logic         as_cb;
    logic [n-1:0] as_sum;
    logic         as_cout;
    logic [n-1:0] res_d;
    logic         cb_d;
    // INC/DEC reuse the adder as a+0+1 / a-0-1 so B and CB_in never reach them
    assign arith   = (Mode == OP_ADD) || (Mode == OP_SUB);
    assign use_sub = (Mode == OP_SUB) || (Mode == OP_DEC);
    assign as_b    = arith ? B : '0;
    assign as_cb   = arith ? CB_in : 1'b1;
    alu_nbit_addsub #(.n(n)) u_addsub (
        .a      (A),
        .b      (as_b),
        .cb_in  (as_cb),
        .sub    (use_sub),
        .sum    (as_sum),
        .cb_out (as_cout)
    );
    always_comb begin
        res_d = as_sum;
        cb_d  = 1'b0;
        case (Mode)
            OP_AND:  res_d = A & B;
            OP_OR:   res_d = A | B;
            OP_XOR:  res_d = A ^ B;
            OP_NOT:  res_d = ~A;
            default: cb_d  = as_cout;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            Result <= '0;
            CB_out <= 1'b0;
        end else begin
            Result <= res_d;
            CB_out <= cb_d;
        end
    end
endmodule

// File: tb/tb_alu_nbit.sv
// tb_alu_nbit: directed self-checking bench for alu_nbit at n=4
module tb_alu_nbit;
    import alu_pkg::*;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B;
    logic [2:0] Mode;
    logic       CB_in;
    logic [3:0] Result;
    logic       CB_out;
    int         n_assert = 0;
    int         n_fail = 0;
    alu_nbit #(.n(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .Mode   (Mode),
        .CB_in  (CB_in),
        .Result (Result),
        .CB_out (CB_out)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [3:0] er, input logic ec);
        n_assert++;
        assert (Result === er) else begin
            n_fail++;
            $error("FAIL %s: Result=%b expected %b", tag, Result, er);
        end
        n_assert++;
        assert (CB_out === ec) else begin
            n_fail++;
            $error("FAIL %s: CB_out=%b expected %b", tag, CB_out, ec);
        end
    endtask
    // Drive one vector, let one edge pass, then check away from the edge
    task automatic step(input string tag, input logic [2:0] m, input logic [3:0] a,
                        input logic [3:0] b, input logic c, input logic [3:0] er, input logic ec);
        Mode  = m;
        A     = a;
        B     = b;
        CB_in = c;
        @(posedge clk);
        #1;
        check(tag, er, ec);
    endtask
    initial begin
        rst = 1'b1;
        step("reset",      OP_ADD, 4'd15, 4'd15, 1'b1, 4'b0000, 1'b0);
        rst = 1'b0;
        step("post_reset", OP_ADD, 4'd15, 4'd15, 1'b1, 4'b1111, 1'b1);
        step("add_4_2_1",  OP_ADD, 4'd4,  4'd2,  1'b1, 4'b0111, 1'b0);
        step("add_8_14_1", OP_ADD, 4'd8,  4'd14, 1'b1, 4'b0111, 1'b1);
        step("add_5_12_0", OP_ADD, 4'd5,  4'd12, 1'b0, 4'b0001, 1'b1);
        step("sub_4_2",    OP_SUB, 4'd4,  4'd2,  1'b0, 4'b0010, 1'b0);
        step("sub_8_14",   OP_SUB, 4'd8,  4'd14, 1'b0, 4'b1010, 1'b1);
        step("sub_5_12",   OP_SUB, 4'd5,  4'd12, 1'b0, 4'b1001, 1'b1);
        step("sub_4_2_1",  OP_SUB, 4'd4,  4'd2,  1'b1, 4'b0001, 1'b0);
        step("sub_0_0_1",  OP_SUB, 4'd0,  4'd0,  1'b1, 4'b1111, 1'b1);
        step("and_8_14",   OP_AND, 4'd8,  4'd14, 1'b1, 4'b1000, 1'b0);
        step("or_5_12",    OP_OR,  4'd5,  4'd12, 1'b1, 4'b1101, 1'b0);
        step("xor_4_2",    OP_XOR, 4'd4,  4'd2,  1'b0, 4'b0110, 1'b0);
        step("xor_5_12",   OP_XOR, 4'd5,  4'd12, 1'b1, 4'b1001, 1'b0);
        step("not_11",     OP_NOT, 4'd11, 4'd3,  1'b1, 4'b0100, 1'b0);
        step("not_5",      OP_NOT, 4'd5,  4'd0,  1'b0, 4'b1010, 1'b0);
        step("inc_11",     OP_INC, 4'd11, 4'd0,  1'b0, 4'b1100, 1'b0);
        step("inc_15",     OP_INC, 4'd15, 4'd0,  1'b0, 4'b0000, 1'b1);
        step("dec_8",      OP_DEC, 4'd8,  4'd0,  1'b0, 4'b0111, 1'b0);
        step("dec_0",      OP_DEC, 4'd0,  4'd0,  1'b0, 4'b1111, 1'b1);
        step("inc_15_bx",  OP_INC, 4'd15, 4'bxxxx, 1'bx, 4'b0000, 1'b1);
        step("dec_0_bx",   OP_DEC, 4'd0,  4'bxxxx, 1'bx, 4'b1111, 1'b1);
        step("inc_11_b1",  OP_INC, 4'd11, 4'b1111, 1'b1, 4'b1100, 1'b0);
        step("dec_8_b1",   OP_DEC, 4'd8,  4'b1111, 1'b1, 4'b0111, 1'b0);
        step("not_5_bx",   OP_NOT, 4'd5,  4'bxxxx, 1'bx, 4'b1010, 1'b0);
        // Alternate carry-producing and logic modes so a stale CB_out would show
        step("b2b_add",    OP_ADD, 4'd15, 4'd0,  1'b1, 4'b0000, 1'b1);
        step("b2b_and",    OP_AND, 4'd12, 4'd10, 1'b1, 4'b1000, 1'b0);
        step("b2b_sub",    OP_SUB, 4'd0,  4'd1,  1'b0, 4'b1111, 1'b1);
        step("b2b_or",     OP_OR,  4'd1,  4'd2,  1'b1, 4'b0011, 1'b0);
        step("b2b_inc",    OP_INC, 4'd15, 4'd7,  1'b1, 4'b0000, 1'b1);
        step("b2b_xor",    OP_XOR, 4'd15, 4'd10, 1'b1, 4'b0101, 1'b0);
        step("b2b_dec",    OP_DEC, 4'd0,  4'd7,  1'b1, 4'b1111, 1'b1);
        step("b2b_not",    OP_NOT, 4'd15, 4'd7,  1'b1, 4'b0000, 1'b0);
        rst = 1'b1;
        step("reset_prio", OP_SUB, 4'd0,  4'd9,  1'b1, 4'b0000, 1'b0);
        rst = 1'b0;
        step("after_rst",  OP_SUB, 4'd0,  4'd9,  1'b1, 4'b0110, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
